// File: rtl/mem_wait_bridge_if.sv
// Memory-side request/acknowledge bus of the wait-state bridge.
// The bridge drives it through the master modport; the memory uses the slave modport.
interface mem_wait_bridge_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   modport master (
      output mem_req, mem_we, mem_adr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_adr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mem_wait_bridge.sv
// Wait-state bridge: registers each controller memory access onto a req/ack bus and stalls
// the controller until the access completes or the watchdog gives up on it.
//
//   state  | meaning
//   S_IDLE | no access outstanding; a MemAccess request is latched and issued
//   S_WAIT | mem_req held high, waiting for mem_ack or watchdog expiry
//   S_DONE | access finished; Stall released for one cycle so the controller advances
module mem_wait_bridge #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    MemAccess,
   input  logic                    MemWrite,
   input  logic [AW-1:0]           Adr,
   input  logic [DW-1:0]           WriteData,
   output logic [DW-1:0]           ReadData,
   output logic                    Stall,
   output logic                    BusErr,
   mem_wait_bridge_if.master       mem
);

   localparam int             CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   // Gating with reset keeps Stall low while the block is held in reset.
   assign Stall = reset & MemAccess & (state != S_DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         cnt           <= '0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_adr   <= '0;
         mem.mem_wdata <= '0;
         ReadData      <= '0;
         BusErr        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (MemAccess) begin
                  mem.mem_req   <= 1'b1;
                  mem.mem_we    <= MemWrite;
                  mem.mem_adr   <= Adr;
                  mem.mem_wdata <= WriteData;
                  cnt           <= '0;
                  state         <= S_WAIT;
               end
            end
            S_WAIT: begin
               // An ack in the final watchdog cycle still wins over the timeout.
               if (mem.mem_ack) begin
                  if (!mem.mem_we) ReadData <= mem.mem_rdata;
                  mem.mem_req <= 1'b0;
                  mem.mem_we  <= 1'b0;
                  state       <= S_DONE;
               end else if (cnt == CNT_LAST) begin
                  mem.mem_req <= 1'b0;
                  mem.mem_we  <= 1'b0;
                  ReadData    <= '0;
                  BusErr      <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_wait_bridge.sv
// Directed bench for mem_wait_bridge: one instance with the default watchdog, one with TIMEOUT=4.
module tb_mem_wait_bridge;

   logic        clk;
   logic        reset;
   logic        acc_a, acc_b;
   logic        we_in;
   logic [31:0] adr_in;
   logic [31:0] wd_in;
   logic [31:0] rd_a, rd_b;
   logic        stall_a, stall_b;
   logic        err_a, err_b;

   int n_chk = 0;
   int n_err = 0;

   mem_wait_bridge_if #(.AW(32), .DW(32)) bus_a ();
   mem_wait_bridge_if #(.AW(32), .DW(32)) bus_b ();

   mem_wait_bridge #(.AW(32), .DW(32)) dut_a (
      .clk       (clk),
      .reset     (reset),
      .MemAccess (acc_a),
      .MemWrite  (we_in),
      .Adr       (adr_in),
      .WriteData (wd_in),
      .ReadData  (rd_a),
      .Stall     (stall_a),
      .BusErr    (err_a),
      .mem       (bus_a)
   );

   mem_wait_bridge #(.AW(32), .DW(32), .TIMEOUT(4)) dut_b (
      .clk       (clk),
      .reset     (reset),
      .MemAccess (acc_b),
      .MemWrite  (we_in),
      .Adr       (adr_in),
      .WriteData (wd_in),
      .ReadData  (rd_b),
      .Stall     (stall_b),
      .BusErr    (err_b),
      .mem       (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      acc_a = 1'b1;
      acc_b = 1'b1;
      we_in = 1'b0;
      adr_in = '0;
      wd_in = '0;
      bus_a.mem_ack = 1'b0;  bus_a.mem_rdata = '0;
      bus_b.mem_ack = 1'b0;  bus_b.mem_rdata = '0;

      // reset state, with MemAccess high to show Stall is gated
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall_a", stall_a, 0);
      chk("rst_stall_b", stall_b, 0);
      chk("rst_req", bus_a.mem_req, 0);
      chk("rst_we", bus_a.mem_we, 0);
      chk("rst_adr", bus_a.mem_adr, 0);
      chk("rst_wdata", bus_a.mem_wdata, 0);
      chk("rst_rdata", rd_a, 0);
      chk("rst_buserr", err_a, 0);
      acc_a = 1'b0;
      acc_b = 1'b0;
      tick(); reset = 1'b1;
      tick();

      // read 0x100, ack in cycle 1
      acc_a = 1'b1; we_in = 1'b0; adr_in = 32'h100;
      @(negedge clk);
      chk("rd_c0_stall", stall_a, 1);
      chk("rd_c0_req", bus_a.mem_req, 0);
      tick(); bus_a.mem_ack = 1'b1; bus_a.mem_rdata = 32'hE3A0_0005;
      @(negedge clk);
      chk("rd_c1_stall", stall_a, 1);
      chk("rd_c1_req", bus_a.mem_req, 1);
      chk("rd_c1_adr", bus_a.mem_adr, 32'h100);
      chk("rd_c1_we", bus_a.mem_we, 0);
      tick(); bus_a.mem_ack = 1'b0; bus_a.mem_rdata = '0;
      @(negedge clk);
      chk("rd_c2_stall", stall_a, 0);
      chk("rd_c2_data", rd_a, 32'hE3A0_0005);
      chk("rd_c2_req", bus_a.mem_req, 0);
      tick(); acc_a = 1'b0;
      @(negedge clk);
      chk("rd_c3_req", bus_a.mem_req, 0);

      // store 0xCAFEF00D to 0x200, ack in cycle 6; inputs change mid-access
      tick(); acc_a = 1'b1; we_in = 1'b1; adr_in = 32'h200; wd_in = 32'hCAFE_F00D;
      @(negedge clk);
      chk("st_c0_stall", stall_a, 1);
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 2) begin adr_in = 32'h999; wd_in = '0; we_in = 1'b0; end
         if (c == 6) begin bus_a.mem_ack = 1'b1; bus_a.mem_rdata = 32'h1234_5678; end
         @(negedge clk);
         chk($sformatf("st_c%0d_we", c), bus_a.mem_we, 1);
         chk($sformatf("st_c%0d_adr", c), bus_a.mem_adr, 32'h200);
         chk($sformatf("st_c%0d_wdata", c), bus_a.mem_wdata, 32'hCAFE_F00D);
         chk($sformatf("st_c%0d_req", c), bus_a.mem_req, 1);
         chk($sformatf("st_c%0d_stall", c), stall_a, 1);
      end
      tick(); bus_a.mem_ack = 1'b0;
      @(negedge clk);
      chk("st_c7_stall", stall_a, 0);
      chk("st_c7_rdata", rd_a, 32'hE3A0_0005);
      chk("st_c7_we", bus_a.mem_we, 0);
      chk("st_c7_req", bus_a.mem_req, 0);
      tick(); acc_a = 1'b0;

      // spurious ack in IDLE
      tick(); bus_a.mem_ack = 1'b1; bus_a.mem_rdata = 32'hFFFF_FFFF;
      tick(); bus_a.mem_ack = 1'b0;
      @(negedge clk);
      chk("sp_idle_rdata", rd_a, 32'hE3A0_0005);
      chk("sp_idle_req", bus_a.mem_req, 0);

      // spurious ack in DONE
      tick(); acc_a = 1'b1; we_in = 1'b0; adr_in = 32'h104;
      tick(); bus_a.mem_ack = 1'b1; bus_a.mem_rdata = 32'h1111_1111;
      tick(); bus_a.mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("sp_done_stall", stall_a, 0);
      chk("sp_done_rdata", rd_a, 32'h1111_1111);
      tick(); bus_a.mem_ack = 1'b0; acc_a = 1'b0;
      @(negedge clk);
      chk("sp_post_rdata", rd_a, 32'h1111_1111);
      chk("sp_post_req", bus_a.mem_req, 0);

      // MemAccess dropped during WAIT: store still completes
      tick(); acc_a = 1'b1; we_in = 1'b1; adr_in = 32'h208; wd_in = 32'h55;
      tick(); acc_a = 1'b0;
      @(negedge clk);
      chk("drop_c1_req", bus_a.mem_req, 1);
      chk("drop_c1_we", bus_a.mem_we, 1);
      chk("drop_c1_stall", stall_a, 0);
      tick(); bus_a.mem_ack = 1'b1;
      @(negedge clk);
      chk("drop_c2_req", bus_a.mem_req, 1);
      tick(); bus_a.mem_ack = 1'b0;
      @(negedge clk);
      chk("drop_c3_req", bus_a.mem_req, 0);
      chk("drop_c3_we", bus_a.mem_we, 0);
      tick();
      @(negedge clk);
      chk("drop_c4_req", bus_a.mem_req, 0);

      // TIMEOUT=4 instance: good read first so the abort-zeroing is visible
      tick(); acc_b = 1'b1; we_in = 1'b0; adr_in = 32'h300;
      tick(); bus_b.mem_ack = 1'b1; bus_b.mem_rdata = 32'hA5A5_A5A5;
      tick(); bus_b.mem_ack = 1'b0;
      @(negedge clk);
      chk("b_rd_data", rd_b, 32'hA5A5_A5A5);
      chk("b_rd_stall", stall_b, 0);
      tick(); acc_b = 1'b0;

      // no ack: watchdog expiry
      tick(); acc_b = 1'b1; adr_in = 32'h304;
      for (int c = 1; c <= 4; c++) begin
         tick();
         @(negedge clk);
         chk($sformatf("to_c%0d_req", c), bus_b.mem_req, 1);
         chk($sformatf("to_c%0d_stall", c), stall_b, 1);
         chk($sformatf("to_c%0d_err", c), err_b, 0);
      end
      tick();
      @(negedge clk);
      chk("to_c5_req", bus_b.mem_req, 0);
      chk("to_c5_err", err_b, 1);
      chk("to_c5_rdata", rd_b, 0);
      chk("to_c5_stall", stall_b, 0);
      tick(); acc_b = 1'b0;

      // recovery read, BusErr stays set
      tick(); acc_b = 1'b1; adr_in = 32'h308;
      tick(); bus_b.mem_ack = 1'b1; bus_b.mem_rdata = 32'h5555_AAAA;
      tick(); bus_b.mem_ack = 1'b0;
      @(negedge clk);
      chk("rec_rdata", rd_b, 32'h5555_AAAA);
      chk("rec_err", err_b, 1);
      chk("rec_stall", stall_b, 0);
      tick(); acc_b = 1'b0;

      // reset asserted in cycle 3 of WAIT
      tick(); acc_b = 1'b1; adr_in = 32'h30C;
      tick(); tick(); tick();
      @(negedge clk);
      chk("mrst_pre_req", bus_b.mem_req, 1);
      reset = 1'b0;
      #1;
      chk("mrst_req", bus_b.mem_req, 0);
      chk("mrst_stall", stall_b, 0);
      chk("mrst_err", err_b, 0);
      chk("mrst_rdata", rd_b, 0);
      tick(); acc_b = 1'b0; reset = 1'b1;
      tick();
      @(negedge clk);
      chk("mrst_idle_req", bus_b.mem_req, 0);

      // ack coincides with the last watchdog cycle
      tick(); acc_b = 1'b1; adr_in = 32'h310;
      tick(); tick(); tick();
      tick(); bus_b.mem_ack = 1'b1; bus_b.mem_rdata = 32'h0BAD_BEEF;
      @(negedge clk);
      chk("ack4_c4_req", bus_b.mem_req, 1);
      chk("ack4_c4_stall", stall_b, 1);
      tick(); bus_b.mem_ack = 1'b0;
      @(negedge clk);
      chk("ack4_err", err_b, 0);
      chk("ack4_rdata", rd_b, 32'h0BAD_BEEF);
      chk("ack4_stall", stall_b, 0);
      chk("ack4_req", bus_b.mem_req, 0);
      tick(); acc_b = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
